// File: rtl/dice_cgra_pkg.sv
// Shared constants and types for the CGRA configuration path.
package dice_cgra_pkg;

  localparam int NUM_TILES      = 16;
  localparam int TILE_CFG_W     = 156;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_TILE = (TILE_CFG_W + WORD_W - 1) / WORD_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY
  } cfg_ld_state_e;

  typedef logic [TILE_CFG_W-1:0] tile_cfg_t;

endpackage

// File: rtl/dice_cfg_tile_assembler.sv
// Packs the stream words of one tile into a staging register and presents the
// completed, truncated tile slot together with a write strobe. The last word is
// merged combinationally so the slot is written on the same edge it is accepted.
module dice_cfg_tile_assembler #(
  parameter int TILE_W = dice_cgra_pkg::TILE_CFG_W,
  parameter int WORD_W = dice_cgra_pkg::WORD_W,
  parameter int NWORDS = dice_cgra_pkg::WORDS_PER_TILE,
  localparam int IDX_W = $clog2(NWORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              word_we,
  input  logic [IDX_W-1:0]  word_idx,
  input  logic [WORD_W-1:0] word,
  output logic [TILE_W-1:0] tile_slot,
  output logic              tile_we
);

  localparam int STAGE_W = NWORDS * WORD_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  logic [STAGE_W-1:0] staging;
  logic [STAGE_W-1:0] merged;

  // Overlay the incoming word onto the staged words of the current tile.
  always_comb begin
    merged = staging;
    if (word_we) merged[int'(word_idx)*WORD_W +: WORD_W] = word;
  end

  // Hold accepted words until the tile is complete.
  always_ff @(posedge clk) begin
    if (rst || clear) staging <= '0;
    else if (word_we) staging <= merged;
  end

  // Upper pad bits of the final word are dropped here.
  assign tile_slot = merged[TILE_W-1:0];
  assign tile_we   = word_we && (word_idx == LAST_IDX);

endmodule

// File: rtl/dice_cgra_cfg_loader.sv
// Loads a 32-bit word stream into a shadow configuration bank and copies it
// atomically into the active bank driving the CGRA when committed while idle.
module dice_cgra_cfg_loader #(
  parameter int NUM_TILES  = 16,
  parameter int TILE_CFG_W = 156,
  parameter int WORD_W     = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            cfg_word_valid,
  input  logic [WORD_W-1:0]               cfg_word,
  output logic                            cfg_word_ready,
  input  logic                            commit,
  input  logic                            cgra_busy,
  output logic                            load_done,
  output logic                            cfg_valid,
  output logic [NUM_TILES*TILE_CFG_W-1:0] cgra_cfg
);
  import dice_cgra_pkg::*;

  localparam int WORDS_PER_TILE = (TILE_CFG_W + WORD_W - 1) / WORD_W;
  localparam int CFG_W          = NUM_TILES * TILE_CFG_W;
  localparam int TILE_IDX_W     = $clog2(NUM_TILES);
  localparam int WORD_IDX_W     = $clog2(WORDS_PER_TILE);
  localparam logic [TILE_IDX_W-1:0] LAST_TILE = TILE_IDX_W'(NUM_TILES - 1);
  localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(WORDS_PER_TILE - 1);

  cfg_ld_state_e           state;
  logic [TILE_IDX_W-1:0]   tile_cnt;
  logic [WORD_IDX_W-1:0]   word_cnt;
  logic                    commit_pending;
  logic [TILE_CFG_W-1:0]   shadow [NUM_TILES];
  logic [CFG_W-1:0]        shadow_flat;
  logic [TILE_CFG_W-1:0]   tile_slot;
  logic                    tile_we;
  logic                    accept;
  logic                    restart;
  logic                    transfer;

  assign accept   = (state == LOAD) && cfg_word_valid && cfg_word_ready;
  // start is ignored mid-load; from IDLE or READY it (re)opens a load.
  assign restart  = start && (state != LOAD);
  // A simultaneous start wins over commit and keeps the request pending.
  assign transfer = (state == READY) && !start && (commit || commit_pending) && !cgra_busy;

  dice_cfg_tile_assembler #(
    .TILE_W (TILE_CFG_W),
    .WORD_W (WORD_W),
    .NWORDS (WORDS_PER_TILE)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (restart),
    .word_we   (accept),
    .word_idx  (word_cnt),
    .word      (cfg_word),
    .tile_slot (tile_slot),
    .tile_we   (tile_we)
  );

  // Load sequencer: state, word/tile counters, handshake and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      tile_cnt       <= '0;
      word_cnt       <= '0;
      commit_pending <= 1'b0;
      cfg_word_ready <= 1'b0;
      load_done      <= 1'b0;
      cfg_valid      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state          <= LOAD;
            tile_cnt       <= '0;
            word_cnt       <= '0;
            cfg_word_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            if (word_cnt == LAST_WORD) begin
              word_cnt <= '0;
              tile_cnt <= tile_cnt + 1'b1;
              if (tile_cnt == LAST_TILE) begin
                state          <= READY;
                cfg_word_ready <= 1'b0;
                load_done      <= 1'b1;
              end
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        READY: begin
          if (start) begin
            state          <= LOAD;
            tile_cnt       <= '0;
            word_cnt       <= '0;
            cfg_word_ready <= 1'b1;
            load_done      <= 1'b0;
          end else if (transfer) begin
            state     <= IDLE;
            load_done <= 1'b0;
            cfg_valid <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          cfg_word_ready <= 1'b0;
          load_done      <= 1'b0;
        end
      endcase

      // A commit seen in IDLE has nothing to act on and is dropped.
      if (transfer || (state == IDLE)) commit_pending <= 1'b0;
      else if (commit)                 commit_pending <= 1'b1;
    end
  end

  // Shadow bank: cleared when a load opens, written one tile at a time.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      for (int t = 0; t < NUM_TILES; t++) shadow[t] <= '0;
    end else if (tile_we) begin
      shadow[tile_cnt] <= tile_slot;
    end
  end

  // Flatten the shadow bank into the CGRA bus layout.
  always_comb begin
    shadow_flat = '0;
    for (int t = 0; t < NUM_TILES; t++) shadow_flat[t*TILE_CFG_W +: TILE_CFG_W] = shadow[t];
  end

  // Active bank: replaced in full, only on a transfer.
  always_ff @(posedge clk) begin
    if (rst)           cgra_cfg <= '0;
    else if (transfer) cgra_cfg <= shadow_flat;
  end

endmodule

// File: tb/tb_dice_cgra_cfg_loader.sv
// Directed bench for the CGRA configuration loader.
module tb_dice_cgra_cfg_loader;

  localparam int NT    = 16;
  localparam int TW    = 156;
  localparam int CFG_W = NT * TW;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             cfg_word_valid;
  logic [31:0]      cfg_word;
  logic             cfg_word_ready;
  logic             commit;
  logic             cgra_busy;
  logic             load_done;
  logic             cfg_valid;
  logic [CFG_W-1:0] cgra_cfg;

  int checks = 0;
  int errors = 0;
  logic [CFG_W-1:0] exp_a;
  logic [CFG_W-1:0] exp_a5;
  logic [CFG_W-1:0] zero_cfg;

  dice_cgra_cfg_loader dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_word_valid (cfg_word_valid),
    .cfg_word       (cfg_word),
    .cfg_word_ready (cfg_word_ready),
    .commit         (commit),
    .cgra_busy      (cgra_busy),
    .load_done      (load_done),
    .cfg_valid      (cfg_valid),
    .cgra_cfg       (cgra_cfg)
  );

  always #5 clk = ~clk;

  // Stream word idx (tile idx/5, word idx%5) for a given pattern.
  function automatic logic [31:0] word_of(input int pat, input int idx);
    int t;
    int k;
    t = idx / 5;
    k = idx % 5;
    case (pat)
      0:       return (t == 15 && k == 4) ? 32'hFFFF_FFFF : 32'((t << 8) | k);
      1:       return 32'h5A5A_0000 | 32'((t << 8) | k);
      default: return 32'hA5A5_A5A5;
    endcase
  endfunction

  // Expected bus image: word k of tile t at tile_base + k*32, bits >= 156 dropped.
  function automatic logic [CFG_W-1:0] exp_of(input int pat);
    logic [CFG_W-1:0] e;
    logic [31:0]      w;
    e = '0;
    for (int idx = 0; idx < 80; idx++) begin
      w = word_of(pat, idx);
      for (int b = 0; b < 32; b++)
        if ((idx % 5) * 32 + b < TW) e[(idx / 5) * TW + (idx % 5) * 32 + b] = w[b];
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_cfg(input string tag, input logic [CFG_W-1:0] exp);
    int bad;
    bad = 0;
    checks++;
    assert (cgra_cfg === exp) else begin
      errors++;
      for (int t = NT - 1; t >= 0; t--)
        if (cgra_cfg[t*TW +: TW] !== exp[t*TW +: TW]) bad = t;
      $error("FAIL %s: tile %0d observed %h expected %h", tag, bad,
             cgra_cfg[bad*TW +: TW], exp[bad*TW +: TW]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream 80 words; optional ~50% valid gaps and a start pulse at word 40.
  task automatic feed(input int pat, input bit gaps, input bit mid_start, input string tag);
    int  idx;
    int  cycles;
    bit  v;
    bit  rdy;
    bit  mid_done;
    idx = 0;
    cycles = 0;
    mid_done = 0;
    while (idx < 80 && cycles < 1000) begin
      v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      cfg_word_valid = v;
      cfg_word = word_of(pat, idx);
      if (mid_start && idx == 40 && v && !mid_done) begin
        start = 1'b1;
        mid_done = 1;
      end
      rdy = cfg_word_ready;
      if (!rdy) chk({tag, "_ready_during_load"}, 64'(rdy), 64'd1);
      tick();
      start = 1'b0;
      if (v && rdy) idx++;
      cycles++;
    end
    cfg_word_valid = 1'b0;
    chk({tag, "_words_accepted"}, 64'(idx), 64'd80);
    if (!gaps) chk({tag, "_load_cycles"}, 64'(cycles), 64'd80);
    chk({tag, "_load_done"}, 64'(load_done), 64'd1);
    chk({tag, "_ready_low"}, 64'(cfg_word_ready), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_word_valid = 1'b0;
    cfg_word = '0;
    commit = 1'b0;
    cgra_busy = 1'b0;
    zero_cfg = '0;
    exp_a  = exp_of(0);
    exp_a5 = exp_of(2);

    repeat (2) tick();
    chk("rst_ready", 64'(cfg_word_ready), 64'd0);
    chk("rst_load_done", 64'(load_done), 64'd0);
    chk("rst_cfg_valid", 64'(cfg_valid), 64'd0);
    chk_cfg("rst_cgra_cfg", zero_cfg);
    rst = 1'b0;
    tick();

    // Gap-free load with an ignored start at word 40, then immediate commit.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("a_ready_after_start", 64'(cfg_word_ready), 64'd1);
    chk("a_load_done_low", 64'(load_done), 64'd0);
    feed(0, 1'b0, 1'b1, "a");
    chk_cfg("a_precommit_zero", zero_cfg);
    chk("a_precommit_valid", 64'(cfg_valid), 64'd0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk_cfg("a_commit", exp_a);
    chk("a_cfg_valid", 64'(cfg_valid), 64'd1);
    chk("a_load_done_cleared", 64'(load_done), 64'd0);
    chk("a_t5w2", 64'(cgra_cfg[5*TW+64 +: 32]), 64'h0502);
    chk("a_t15w4_trunc", 64'(cgra_cfg[2495:2464]), 64'hFFFF_FFF0);

    // Reset in the middle of a load clears the committed configuration too.
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_word_valid = 1'b1;
    cfg_word = 32'h1234_5678;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cfg_word_valid = 1'b0;
    chk("b_rst_ready", 64'(cfg_word_ready), 64'd0);
    chk("b_rst_load_done", 64'(load_done), 64'd0);
    chk("b_rst_cfg_valid", 64'(cfg_valid), 64'd0);
    chk_cfg("b_rst_cgra_cfg", zero_cfg);

    // Commit in IDLE is dropped; gapped load must match the gap-free image.
    commit = 1'b1;
    tick();
    commit = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(0, 1'b1, 1'b0, "c");
    repeat (3) tick();
    chk("c_idle_commit_dropped", 64'(cfg_valid), 64'd0);
    chk("c_still_ready", 64'(load_done), 64'd1);
    chk_cfg("c_no_transfer", zero_cfg);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk_cfg("c_gapped_commit", exp_a);
    chk("c_cfg_valid", 64'(cfg_valid), 64'd1);

    // Load B, then start+commit in READY: start wins, commit stays pending.
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(1, 1'b0, 1'b0, "d");
    chk_cfg("d_b_not_committed", exp_a);
    start = 1'b1;
    commit = 1'b1;
    tick();
    start = 1'b0;
    commit = 1'b0;
    cgra_busy = 1'b1;
    chk("d_restart_load_done", 64'(load_done), 64'd0);
    chk("d_restart_ready", 64'(cfg_word_ready), 64'd1);
    chk("d_restart_cfg_valid", 64'(cfg_valid), 64'd1);
    chk_cfg("d_restart_active_kept", exp_a);
    feed(2, 1'b0, 1'b0, "e");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_cfg("e_busy_hold", exp_a);
      chk("e_busy_load_done", 64'(load_done), 64'd1);
    end
    cgra_busy = 1'b0;
    tick();
    chk_cfg("e_pending_commit", exp_a5);
    chk("e_cfg_valid", 64'(cfg_valid), 64'd1);
    chk("e_load_done_cleared", 64'(load_done), 64'd0);
    tick();
    chk_cfg("e_stable", exp_a5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
